// File: rtl/fm_wr_split_pkg.sv
// Shared widths, burst segmentation constants and FSM state encoding for the
// write splitter on the internal DRAM bus.
package fm_wr_split_pkg;

    localparam int P_IB_ADDR_WIDTH = 29;
    localparam int P_IB_LEN_WIDTH  = 6;
    localparam int P_IB_DATA_WIDTH = 32;
    localparam int P_IB_BE_WIDTH   = 4;
    localparam int P_SEG           = 16;

    localparam logic [P_IB_LEN_WIDTH-1:0] P_SEG_LEN = P_IB_LEN_WIDTH'(P_SEG);

    typedef enum logic [1:0] {
        P_CMD1  = 2'd0,
        P_DATA1 = 2'd1,
        P_CMD2  = 2'd2,
        P_DATA2 = 2'd3
    } state_t;

    // Bit 4 selects the 16-beat half of a 32-beat aligned window.
    function automatic logic [P_IB_ADDR_WIDTH-1:0] seg_adrs(
        input logic [P_IB_ADDR_WIDTH-6:0] hi,
        input logic                       second
    );
        return {hi, second, 4'b0000};
    endfunction

endpackage

// File: rtl/fm_wr_split_if.sv
// Command + write-data handshake bundle used on both sides of the splitter.
interface fm_wr_split_if;
    import fm_wr_split_pkg::*;

    logic                       req;
    logic [P_IB_ADDR_WIDTH-1:0] adrs;
    logic [P_IB_LEN_WIDTH-1:0]  len;
    logic                       ack;
    logic                       wstr;
    logic [P_IB_BE_WIDTH-1:0]   be;
    logic [P_IB_DATA_WIDTH-1:0] wdata;
    logic                       wack;

    modport master (output req, adrs, len, wstr, be, wdata, input ack, wack);
    modport slave  (input req, adrs, len, wstr, be, wdata, output ack, wack);

endinterface

// File: rtl/fm_wr_split.sv
// Splits one upstream write of up to 32 beats into at most two 16-beat DRAM
// bursts; command and data paths are combinational, only the FSM is stateful.
module fm_wr_split
    import fm_wr_split_pkg::*;
(
    input  logic           clk_core,
    input  logic           rst_x,
    fm_wr_split_if.slave   up,
    fm_wr_split_if.master  dn
);

    state_t                    state;
    logic [P_IB_LEN_WIDTH-1:0] r_cnt;
    logic                      r_split;

    logic                      w_split;
    logic [P_IB_LEN_WIDTH-1:0] w_len1;
    logic [P_IB_LEN_WIDTH-1:0] w_len2;
    logic                      w_in_data;
    logic                      w_beat;
    logic                      w_last;
    logic                      unused_adrs_lo;

    assign w_split   = (up.len > P_SEG_LEN);
    assign w_len1    = w_split ? P_SEG_LEN : up.len;
    assign w_len2    = up.len - P_SEG_LEN;
    assign w_in_data = (state == P_DATA1) || (state == P_DATA2);
    assign w_beat    = w_in_data && up.wstr && dn.wack;
    assign w_last    = w_beat && (r_cnt == P_IB_LEN_WIDTH'(1));

    // Low address bits are implied by the 32-beat alignment of upstream commands.
    assign unused_adrs_lo = &{1'b0, up.adrs[4:0]};

    assign dn.req   = (state == P_CMD1) ? up.req : (state == P_CMD2);
    assign dn.len   = (state == P_CMD2) ? w_len2 : w_len1;
    assign dn.adrs  = seg_adrs(up.adrs[P_IB_ADDR_WIDTH-1:5], state == P_CMD2);
    assign up.ack   = ((state == P_CMD1) && up.req && dn.ack && !w_split) ||
                      ((state == P_CMD2) && dn.ack);

    assign dn.wstr  = w_in_data && up.wstr;
    assign up.wack  = w_in_data && dn.wack;
    assign dn.be    = up.be;
    assign dn.wdata = up.wdata;

    always_ff @(posedge clk_core or negedge rst_x) begin
        if (!rst_x) begin
            state   <= P_CMD1;
            r_cnt   <= '0;
            r_split <= 1'b0;
        end else begin
            case (state)
                P_CMD1: begin
                    if (up.req && dn.ack) begin
                        r_split <= w_split;
                        r_cnt   <= w_len1;
                        // A zero-length command is acked without entering a data phase.
                        state   <= (up.len == '0) ? P_CMD1 : P_DATA1;
                    end
                end
                P_DATA1: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt - P_IB_LEN_WIDTH'(1);
                        if (w_last) state <= r_split ? P_CMD2 : P_CMD1;
                    end
                end
                P_CMD2: begin
                    if (dn.ack) begin
                        r_cnt <= w_len2;
                        state <= P_DATA2;
                    end
                end
                P_DATA2: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt - P_IB_LEN_WIDTH'(1);
                        if (w_last) state <= P_CMD1;
                    end
                end
                default: state <= P_CMD1;
            endcase
        end
    end

endmodule

// File: tb/tb_fm_wr_split.sv
// Directed bench for fm_wr_split: single, split, boundary, stalled,
// back-to-back and mid-burst reset scenarios.
module tb_fm_wr_split;
    import fm_wr_split_pkg::*;

    localparam int AW = P_IB_ADDR_WIDTH;
    localparam int LW = P_IB_LEN_WIDTH;

    logic clk_core = 1'b0;
    logic rst_x    = 1'b0;

    fm_wr_split_if up_if();
    fm_wr_split_if dn_if();

    fm_wr_split dut (
        .clk_core (clk_core),
        .rst_x    (rst_x),
        .up       (up_if),
        .dn       (dn_if)
    );

    always #5 clk_core = ~clk_core;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] word  = 32'h1000_0000;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_core);
        #1;
    endtask

    task automatic idle_inputs();
        up_if.req   = 1'b0;
        up_if.adrs  = '0;
        up_if.len   = '0;
        up_if.wstr  = 1'b0;
        up_if.be    = '0;
        up_if.wdata = '0;
        dn_if.ack   = 1'b0;
        dn_if.wack  = 1'b0;
    endtask

    task automatic do_cmd(input logic [AW-1:0] adrs, input logic [LW-1:0] len,
                          input bit stall, input bit hold_next,
                          input logic [AW-1:0] nadrs, input logic [LW-1:0] nlen);
        int nseg;
        nseg = (len > 6'd16) ? 2 : 1;
        up_if.req  = 1'b1;
        up_if.adrs = adrs;
        up_if.len  = len;
        for (int s = 0; s < nseg; s++) begin
            logic [LW-1:0] slen;
            logic [AW-1:0] sadrs;
            int            beats;
            int            guard;
            bit            last_seg;
            last_seg = (s == nseg - 1);
            slen  = (s == 0) ? ((len > 6'd16) ? 6'd16 : len) : (len - 6'd16);
            sadrs = {adrs[AW-1:5], s[0], 4'b0000};
            if (stall) begin
                int w;
                w = $urandom_range(1, 3);
                for (int i = 0; i < w; i++) begin
                    dn_if.ack  = 1'b0;
                    up_if.wstr = 1'b1;
                    dn_if.wack = 1'b1;
                    #2;
                    chk("req_wait", dn_if.req, 1);
                    chk("no_wstr_before_cmd", dn_if.wstr, 0);
                    chk("no_wack_before_cmd", up_if.wack, 0);
                    chk("no_ack_wait", up_if.ack, 0);
                    step();
                end
            end
            dn_if.ack  = 1'b1;
            up_if.wstr = 1'b1;
            dn_if.wack = 1'b1;
            #2;
            chk("cmd_req", dn_if.req, 1);
            chk("cmd_adrs", dn_if.adrs, sadrs);
            chk("cmd_len", dn_if.len, slen);
            chk("cmd_ack", up_if.ack, last_seg);
            chk("cmd_no_wstr", dn_if.wstr, 0);
            chk("cmd_no_wack", up_if.wack, 0);
            step();
            dn_if.ack = 1'b0;
            if (last_seg) begin
                if (hold_next) begin
                    up_if.adrs = nadrs;
                    up_if.len  = nlen;
                end else begin
                    up_if.req = 1'b0;
                end
            end
            beats = 0;
            guard = 0;
            while (beats < int'(slen) && guard < 300) begin
                up_if.wstr  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                dn_if.wack  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                up_if.wdata = word;
                up_if.be    = word[3:0];
                if (hold_next && last_seg) dn_if.ack = 1'b1;
                #2;
                chk("wstr_pass", dn_if.wstr, up_if.wstr);
                chk("wack_pass", up_if.wack, dn_if.wack);
                if (hold_next && last_seg) begin
                    chk("held_req_low", dn_if.req, 0);
                    chk("held_ack_low", up_if.ack, 0);
                end
                if (up_if.wstr && dn_if.wack) begin
                    chk("wdata", dn_if.wdata, word);
                    chk("be", dn_if.be, word[3:0]);
                    beats++;
                    word++;
                end
                guard++;
                step();
            end
            up_if.wstr = 1'b0;
            dn_if.wack = 1'b0;
            dn_if.ack  = 1'b0;
            chk("beat_count", beats, slen);
        end
        up_if.wstr = 1'b1;
        dn_if.wack = 1'b1;
        #2;
        chk("after_no_wstr", dn_if.wstr, 0);
        chk("after_no_wack", up_if.wack, 0);
        up_if.wstr = 1'b0;
        dn_if.wack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        up_if.wstr = 1'b1;
        dn_if.wack = 1'b1;
        dn_if.ack  = 1'b1;
        repeat (2) @(posedge clk_core);
        #1;
        chk("rst_req", dn_if.req, 0);
        chk("rst_ack", up_if.ack, 0);
        chk("rst_wstr", dn_if.wstr, 0);
        chk("rst_wack", up_if.wack, 0);
        idle_inputs();
        rst_x = 1'b1;
        step();

        // Single burst, split 32, 16+1 boundary.
        do_cmd(29'h40, 6'd8,  1'b0, 1'b0, '0, '0);
        do_cmd(29'h20, 6'd32, 1'b0, 1'b0, '0, '0);
        do_cmd(29'h60, 6'd17, 1'b0, 1'b0, '0, '0);
        do_cmd(29'h180, 6'd16, 1'b0, 1'b0, '0, '0);

        // Zero-length: acked in place, no data phase follows.
        step();
        up_if.req  = 1'b1;
        up_if.adrs = 29'h80;
        up_if.len  = 6'd0;
        dn_if.ack  = 1'b1;
        #2;
        chk("len0_ack", up_if.ack, 1);
        chk("len0_len", dn_if.len, 0);
        step();
        up_if.req  = 1'b0;
        dn_if.ack  = 1'b0;
        up_if.wstr = 1'b1;
        dn_if.wack = 1'b1;
        #2;
        chk("len0_no_wstr", dn_if.wstr, 0);
        chk("len0_req", dn_if.req, 0);
        idle_inputs();
        step();

        // Random stalls on both handshakes.
        do_cmd(29'h80, 6'd24, 1'b1, 1'b0, '0, '0);
        step();

        // Back-to-back: next command held off until the last beat.
        do_cmd(29'hA0, 6'd20, 1'b0, 1'b1, 29'hC0, 6'd5);
        do_cmd(29'hC0, 6'd5,  1'b0, 1'b0, '0, '0);
        step();

        // Reset asserted during the second data phase.
        up_if.req  = 1'b1;
        up_if.adrs = 29'h200;
        up_if.len  = 6'd32;
        dn_if.ack  = 1'b1;
        up_if.wstr = 1'b1;
        dn_if.wack = 1'b1;
        #2;
        chk("r6_cmd1_ack", up_if.ack, 0);
        chk("r6_cmd1_req", dn_if.req, 1);
        step();
        for (int i = 0; i < 16; i++) begin
            #2;
            chk("r6_data1_wstr", dn_if.wstr, 1);
            step();
        end
        #2;
        chk("r6_cmd2_req", dn_if.req, 1);
        chk("r6_cmd2_ack", up_if.ack, 1);
        chk("r6_cmd2_adrs", dn_if.adrs, 29'h210);
        chk("r6_cmd2_len", dn_if.len, 16);
        step();
        up_if.req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("r6_data2_wstr", dn_if.wstr, 1);
            step();
        end
        rst_x = 1'b0;
        #1;
        chk("r6_rst_req", dn_if.req, 0);
        chk("r6_rst_ack", up_if.ack, 0);
        chk("r6_rst_wstr", dn_if.wstr, 0);
        chk("r6_rst_wack", up_if.wack, 0);
        idle_inputs();
        step();
        rst_x = 1'b1;
        step();
        do_cmd(29'h100, 6'd8, 1'b0, 1'b0, '0, '0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
